// File: rtl/i_decode.sv
// Decode stage: registers the fetched word, splits fields and tracks pending
// register write-backs so dependent readers stall until their sources land.
module i_decode #(
    parameter int WB_LAT = 3,
    parameter int NREGS  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] instruction,
    output logic        fetch_en,
    output logic        out_valid,
    output logic [3:0]  out_opcode,
    output logic [3:0]  out_funct,
    output logic [3:0]  out_rd,
    output logic [3:0]  out_rs1,
    output logic [3:0]  out_rs2,
    output logic [31:0] out_imm,
    output logic [19:0] out_target,
    output logic        out_writes_rd
);

    localparam logic [3:0] OPC_ARITH = 4'h0;
    localparam logic [3:0] OPC_AR_IM = 4'h1;
    localparam logic [3:0] OPC_TEST  = 4'h2;
    localparam logic [3:0] OPC_TS_IM = 4'h3;
    localparam logic [3:0] OPC_LOAD  = 4'h4;
    localparam logic [3:0] OPC_STORE = 4'h5;
    localparam logic [3:0] OPC_NOOP  = 4'hF;

    logic [NREGS-1:0][2:0] pend_q, pend_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [31:0]           hold_q, hold_d;

    logic        out_valid_q, out_valid_d;
    logic [3:0]  out_opcode_q, out_opcode_d;
    logic [3:0]  out_funct_q, out_funct_d;
    logic [3:0]  out_rd_q, out_rd_d;
    logic [3:0]  out_rs1_q, out_rs1_d;
    logic [3:0]  out_rs2_q, out_rs2_d;
    logic [31:0] out_imm_q, out_imm_d;
    logic [19:0] out_target_q, out_target_d;
    logic        out_writes_rd_q, out_writes_rd_d;

    logic [31:0] cur;
    logic [3:0]  opc, rd, rs1, rs2;
    logic        is_noop, uses_rs2, is_writer, hazard, issue;

    always_comb begin
        cur       = hold_valid_q ? hold_q : instruction;
        opc       = cur[31:28];
        rd        = cur[23:20];
        rs1       = cur[19:16];
        rs2       = cur[15:12];
        is_noop   = (opc == OPC_NOOP);
        uses_rs2  = (opc == OPC_ARITH) || (opc == OPC_TEST) || (opc == OPC_STORE);
        is_writer = (opc == OPC_ARITH) || (opc == OPC_AR_IM) || (opc == OPC_LOAD);

        // r0 has no pend entry in use, so the scan starts at 1.
        hazard = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (!is_noop && pend_q[r] != 3'd0 &&
                ((rs1 == 4'(r)) || (uses_rs2 && rs2 == 4'(r))))
                hazard = 1'b1;
        end

        issue    = run && !hazard && !is_noop;
        fetch_en = run && !rst && !hazard;

        pend_d = '0;
        for (int r = 1; r < NREGS; r++) begin
            pend_d[r] = (pend_q[r] != 3'd0) ? pend_q[r] - 3'd1 : 3'd0;
            if (issue && is_writer && rd == 4'(r))
                pend_d[r] = 3'(WB_LAT);
        end

        hold_valid_d    = hold_valid_q;
        hold_d          = hold_q;
        out_valid_d     = 1'b0;
        out_opcode_d    = OPC_NOOP;
        out_writes_rd_d = 1'b0;
        out_funct_d     = out_funct_q;
        out_rd_d        = out_rd_q;
        out_rs1_d       = out_rs1_q;
        out_rs2_d       = out_rs2_q;
        out_imm_d       = out_imm_q;
        out_target_d    = out_target_q;

        if (issue) begin
            out_valid_d     = 1'b1;
            out_opcode_d    = opc;
            out_funct_d     = cur[27:24];
            out_rd_d        = rd;
            out_rs1_d       = rs1;
            out_rs2_d       = rs2;
            out_imm_d       = {{16{cur[15]}}, cur[15:0]};
            out_target_d    = cur[19:0];
            out_writes_rd_d = is_writer && (rd != 4'd0);
            hold_valid_d    = 1'b0;
        end else if (hazard && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_d       = cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q          <= '0;
            hold_valid_q    <= 1'b0;
            hold_q          <= '0;
            out_valid_q     <= 1'b0;
            out_opcode_q    <= OPC_NOOP;
            out_funct_q     <= '0;
            out_rd_q        <= '0;
            out_rs1_q       <= '0;
            out_rs2_q       <= '0;
            out_imm_q       <= '0;
            out_target_q    <= '0;
            out_writes_rd_q <= 1'b0;
        end else begin
            pend_q          <= pend_d;
            hold_valid_q    <= hold_valid_d;
            hold_q          <= hold_d;
            out_valid_q     <= out_valid_d;
            out_opcode_q    <= out_opcode_d;
            out_funct_q     <= out_funct_d;
            out_rd_q        <= out_rd_d;
            out_rs1_q       <= out_rs1_d;
            out_rs2_q       <= out_rs2_d;
            out_imm_q       <= out_imm_d;
            out_target_q    <= out_target_d;
            out_writes_rd_q <= out_writes_rd_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_opcode    = out_opcode_q;
    assign out_funct     = out_funct_q;
    assign out_rd        = out_rd_q;
    assign out_rs1       = out_rs1_q;
    assign out_rs2       = out_rs2_q;
    assign out_imm       = out_imm_q;
    assign out_target    = out_target_q;
    assign out_writes_rd = out_writes_rd_q;

endmodule

// File: tb/tb_i_decode.sv
// Bench for i_decode: directed hazard scenarios then random traffic, all
// checked against a model that tracks the cycle each register becomes readable.
module tb_i_decode;

    localparam int WB_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [31:0] instruction = 32'hF000_0000;
    logic        fetch_en, out_valid, out_writes_rd;
    logic [3:0]  out_opcode, out_funct, out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm;
    logic [19:0] out_target;

    i_decode #(.WB_LAT(WB_LAT), .NREGS(16)) dut (
        .clk(clk), .rst(rst), .run(run), .instruction(instruction),
        .fetch_en(fetch_en), .out_valid(out_valid), .out_opcode(out_opcode),
        .out_funct(out_funct), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_imm(out_imm), .out_target(out_target),
        .out_writes_rd(out_writes_rd)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOOP = 32'hF000_0000;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: edge count, per-register first edge at which a read may issue,
    // and the single held word.
    int          cyc = 0;
    int          ready [16];
    logic        m_hold_v = 1'b0;
    logic [31:0] m_hold = '0;
    logic        e_valid, e_wr, e_fields;
    logic [3:0]  e_opc, e_funct, e_rd, e_rs1, e_rs2;
    logic [31:0] e_imm;
    logic [19:0] e_target;
    logic        last_fe;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] fn,
                                       input logic [3:0] rd, input logic [3:0] rs1,
                                       input logic [15:0] low);
        return {op, fn, rd, rs1, low};
    endfunction

    task automatic step(input logic r, input logic rn, input logic [31:0] w);
        logic [31:0] c;
        logic [3:0]  op, rs1, rs2, rd;
        logic        haz, u2, wr;
        rst = r; run = rn; instruction = w;
        #2;
        c   = m_hold_v ? m_hold : w;
        op  = c[31:28]; rd = c[23:20]; rs1 = c[19:16]; rs2 = c[15:12];
        u2  = (op == 4'h0) || (op == 4'h2) || (op == 4'h5);
        wr  = (op == 4'h0) || (op == 4'h1) || (op == 4'h4);
        haz = 1'b0;
        if (op != 4'hF) begin
            if (rs1 != 0 && cyc + 1 < ready[rs1]) haz = 1'b1;
            if (u2 && rs2 != 0 && cyc + 1 < ready[rs2]) haz = 1'b1;
        end
        chk("fetch_en", 32'(fetch_en), 32'(rn & ~r & ~haz));
        last_fe = fetch_en;
        @(posedge clk);
        cyc++;
        e_fields = 1'b0;
        if (r) begin
            for (int i = 0; i < 16; i++) ready[i] = 0;
            m_hold_v = 1'b0;
            e_valid = 0; e_opc = 4'hF; e_wr = 0; e_funct = 0; e_rd = 0;
            e_rs1 = 0; e_rs2 = 0; e_imm = 0; e_target = 0; e_fields = 1'b1;
        end else if (rn && !haz && op != 4'hF) begin
            e_valid = 1; e_opc = op; e_funct = c[27:24]; e_rd = rd; e_rs1 = rs1;
            e_rs2 = rs2; e_imm = 32'($signed(c[15:0])); e_target = c[19:0];
            e_wr = wr && rd != 0; e_fields = 1'b1;
            if (wr && rd != 0) ready[rd] = cyc + WB_LAT + 1;
            m_hold_v = 1'b0;
        end else begin
            e_valid = 0; e_opc = 4'hF; e_wr = 0;
            if (haz && !m_hold_v) begin
                m_hold_v = 1'b1;
                m_hold   = c;
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("out_opcode", 32'(out_opcode), 32'(e_opc));
        chk("out_writes_rd", 32'(out_writes_rd), 32'(e_wr));
        if (e_fields) begin
            chk("out_funct", 32'(out_funct), 32'(e_funct));
            chk("out_rd", 32'(out_rd), 32'(e_rd));
            chk("out_rs1", 32'(out_rs1), 32'(e_rs1));
            chk("out_rs2", 32'(out_rs2), 32'(e_rs2));
            chk("out_imm", out_imm, e_imm);
            chk("out_target", 32'(out_target), 32'(e_target));
        end
    endtask

    initial begin
        int lows, issues;
        logic [3:0] op;
        for (int i = 0; i < 16; i++) ready[i] = 0;

        // Reset with garbage on the input, then release.
        step(1, 1, $urandom);
        step(1, 1, $urandom);
        step(0, 1, NOOP);
        chk("fetch_en_after_reset", 32'(last_fe), 32'd1);

        // Field decode of an AR_IM with a negative immediate.
        step(0, 1, mk(4'h1, 4'h2, 4'h3, 4'h4, 16'h8001));
        chk("decode_imm", out_imm, 32'hFFFF_8001);
        chk("decode_rd", 32'(out_rd), 32'd3);
        chk("decode_wr", 32'(out_writes_rd), 32'd1);

        // RAW stall: expect fetch_en low exactly WB_LAT cycles.
        step(0, 1, mk(4'h0, 4'h0, 4'h1, 4'h0, 16'h0000));
        lows = 0; issues = 0;
        step(0, 1, mk(4'h0, 4'h7, 4'h6, 4'h1, 16'h2345));
        if (!last_fe) lows++;
        issues += int'(out_valid);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, NOOP);
            if (!last_fe) lows++;
            issues += int'(out_valid);
        end
        chk("raw_fetch_en_lows", 32'(lows), 32'(WB_LAT));
        chk("raw_reader_issues", 32'(issues), 32'd1);

        // r0 never hazards; AR_IM ignores its rs2 field.
        step(0, 1, mk(4'h0, 4'h0, 4'h0, 4'h2, 16'h0000));
        step(0, 1, mk(4'h2, 4'h0, 4'h0, 4'h0, 16'h0000));
        chk("r0_no_stall", 32'(last_fe), 32'd1);
        step(0, 1, mk(4'h0, 4'h0, 4'h5, 4'h0, 16'h0000));
        step(0, 1, mk(4'h1, 4'h0, 4'h7, 4'h2, 16'h5000));
        chk("rs2_unused_no_stall", 32'(last_fe), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 1, NOOP);

        // Drop run for 5 cycles while holding; held word issues exactly once.
        step(0, 1, mk(4'h4, 4'h0, 4'h8, 4'h0, 16'h0010));
        step(0, 1, mk(4'h5, 4'h1, 4'h0, 4'h8, 16'h0ABC));
        issues = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, NOOP);
            issues += int'(out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, NOOP);
            issues += int'(out_valid);
        end
        chk("run_gate_issues", 32'(issues), 32'd1);

        // Reset during a hold drops the held word and clears the scoreboard.
        step(0, 1, mk(4'h0, 4'h0, 4'h9, 4'h0, 16'h0000));
        step(0, 1, mk(4'h2, 4'h0, 4'h0, 4'h9, 16'h0000));
        step(1, 1, NOOP);
        step(0, 1, mk(4'h2, 4'h3, 4'h0, 4'h9, 16'h0000));
        chk("post_reset_no_bubble", 32'(out_valid), 32'd1);
        step(0, 1, NOOP);
        chk("held_word_dropped", 32'(out_valid), 32'd0);

        // Random traffic on a small register set to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] w;
            op = 4'($urandom_range(0, 14));
            w  = {op, 4'($urandom), 2'b0, 2'($urandom), 2'b0, 2'($urandom),
                  2'b0, 2'($urandom), 12'($urandom)};
            if ($urandom_range(0, 3) == 0) w = NOOP;
            step($urandom_range(0, 49) == 0, $urandom_range(0, 99) < 85, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i_decode.md
# i_decode

Decode stage sitting directly downstream of instruction fetch. It registers each 32-bit instruction word from fetch, splits it into fields for execute, and sign-extends immediates. A per-register write-back scoreboard detects read-after-write hazards. On a hazard it holds the offending instruction, issues bubbles, and deasserts `fetch_en` so fetch stops advancing.

## Interface
- `WB_LAT`, default 3: cycles after issue before a destination register is readable; legal range 1..7.
- `NREGS`, default 16: architectural registers; r0 reads as zero and never hazards.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `run`  in  1  core enable from top level
- `instruction`  in  32  word from fetch; `f000_0000` is a NOOP bubble
- `fetch_en`  out  1  fetch advance enable, combinational: `run & !rst & !hazard`
- `out_valid`  out  1  a real instruction is presented to execute this cycle
- `out_opcode`  out  4  `[31:28]`
- `out_funct`  out  4  `[27:24]`
- `out_rd`  out  4  `[23:20]`
- `out_rs1`  out  4  `[19:16]`
- `out_rs2`  out  4  `[15:12]`
- `out_imm`  out  32  `[15:0]` sign-extended
- `out_target`  out  20  `[19:0]` zero-extended target/offset for control-flow opcodes
- `out_writes_rd`  out  1  instruction writes `rd` and `rd != 0`

## Operation
- Current word `cur`: the hold register when `hold_valid`, else `instruction`.
- Writers: `OPC_ARITH`, `OPC_AR_IM`, `OPC_LOAD`.
- Source usage by opcode:
  - `OPC_ARITH`, `OPC_TEST`, `OPC_STORE`: rs1 and rs2.
  - `OPC_AR_IM`, `OPC_TS_IM`, `OPC_LOAD`: rs1 only.
  - Control-flow (all other non-NOOP) opcodes: rs1 only.
  - `OPC_NOOP`: none.
- Scoreboard: one 3-bit down-counter `pend[r]` per register.
- Hazard: a used source `rs` has `rs != 0` and `pend[rs] != 0`.
- Each cycle, all nonzero `pend` values decrement by 1.
- Issue of a writer with `rd != 0` loads `pend[rd] <= WB_LAT`. This overrides the decrement for that register, so a write-after-write reload is allowed.
- Issue condition: `run && !hazard && opcode != NOOP`. On issue:
  - Fields of `cur` are registered to the outputs and `out_valid <= 1`.
  - `hold_valid <= 0`.
- Bubble, when `!run`, `cur` is NOOP, or a hazard is present:
  - `out_valid <= 0`, `out_opcode <= OPC_NOOP`, `out_writes_rd <= 0`; other output fields are don't-care.
  - On a hazard with `hold_valid == 0`, `cur` is captured into the hold register and `hold_valid <= 1`.
- While `hold_valid`, the input word is ignored. Fetch supplies `f000_0000` while disabled, so no instruction is lost.
- When `run` drops while holding, the hold is kept; issue resumes once `run` returns.
- Reset (synchronous, takes priority over everything):
  - All `pend` cleared; `hold_valid = 0`.
  - `out_valid = 0`, `out_opcode = 4'hF`, all other outputs 0.
  - `fetch_en = 0` while `rst` is high.

## Timing
- Latency is 1 cycle: a word present on `instruction` in cycle t appears on `out_*` in cycle t+1 when issued.
- Hazard detection and `fetch_en` are combinational within the cycle. Fetch's `counter` stays at the next address, so the stalled instruction's successor is fetched on the cycle the held word issues.
- Dependent reader following a writer:
  - Writer issued at edge e; reader decoded in cycle e+1 sees `pend = WB_LAT` and stalls.
  - The reader stalls `WB_LAT` cycles and issues at edge e+1+`WB_LAT`.
  - Resulting `out_valid` pattern: 1, then `WB_LAT` zeros, then 1.
- An independent instruction between writer and reader absorbs one stall cycle.
- Reset asserted mid-stall drops the held word. The first post-reset cycle shows no hazard.
- `fetch_en` may toggle every cycle; there is no minimum low time.

## Test plan
- Reset:
  - Stimulus: hold `rst` 2 cycles with a random `instruction`.
  - Required: `out_valid = 0`, `out_opcode = F`, `fetch_en = 0`; cycle after release, `fetch_en = 1` with `run = 1`.
- Field decode:
  - Stimulus: `OPC_AR_IM`, funct 2, rd 3, rs1 4, imm `0x8001`.
  - Required, next cycle: `out_valid = 1`, `out_rd = 3`, `out_rs1 = 4`, `out_imm = 0xFFFF8001`, `out_writes_rd = 1`.
- RAW stall (`WB_LAT = 3`):
  - Stimulus: `OPC_ARITH` rd 1, then `OPC_ARITH` rs1 1.
  - Required: `out_valid` pattern 1,0,0,0,1; `fetch_en` low exactly 3 cycles; second instruction emitted intact.
- r0 and non-readers:
  - Stimulus: writer rd 0, then reader rs1 0; separately, writer rd 5 followed by `OPC_AR_IM` with rs2 field 5.
  - Required: no stall in either case.
- Run gating:
  - Stimulus: drop `run` during a hazard hold for 5 cycles, then raise it.
  - Required: held word issues after `run` rises, never twice; NOOP inputs never produce `out_valid = 1`.
- Reset mid-stall:
  - Stimulus: assert `rst` during a hold.
  - Required: held word discarded; all `pend` cleared, confirmed by a reader of the old rd issuing with no bubble.
